// File: rtl/complex_mult_scoreboard.sv
// rtl/complex_mult_scoreboard.sv - complex multiplier scoreboard: predicts, queues and checks results
module complex_mult_scoreboard #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int SIGNED     = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          sw_rst,
  input  logic                          op_val,
  input  logic                          op_ready,
  input  logic [4*DATA_WIDTH-1:0]       op_data,
  input  logic                          res_val,
  input  logic                          res_ready,
  input  logic [4*DATA_WIDTH+2:0]       res_data,
  output logic [CNT_WIDTH-1:0]          pass_cnt,
  output logic [CNT_WIDTH-1:0]          fail_cnt,
  output logic [$clog2(DEPTH):0]        pending,
  output logic                          mismatch,
  output logic                          err_sticky,
  output logic                          ovf_sticky,
  output logic                          udf_sticky,
  output logic [CNT_WIDTH-1:0]          first_fail_idx
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [2*PW-1:0]      mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic                 push, pop, fifo_full, fifo_empty;
  logic                 do_push, do_pop, ovf_evt, udf_evt;
  logic                 is_pass, is_fail;
  logic [2*PW-1:0]      head;
  logic [CNT_WIDTH-1:0] txn_idx;
  logic                 unused_res_tag;

  function automatic logic [PW-1:0] ext(input logic [DW-1:0] x);
    if (SIGNED != 0) return {{DW{x[DW-1]}}, x};
    else             return {{DW{1'b0}}, x};
  endfunction

  // Low 2*DW bits of the product of extended operands equal the true product mod 2^(2*DW)
  function automatic logic [2*PW-1:0] predict(input logic [4*DW-1:0] op);
    logic [PW-1:0] ar, ai, br, bi, re, im;
    ar = ext(op[4*DW-1:3*DW]);
    ai = ext(op[3*DW-1:2*DW]);
    br = ext(op[2*DW-1:DW]);
    bi = ext(op[DW-1:0]);
    re = ar * br - ai * bi;
    im = ar * bi + ai * br;
    return {re, im};
  endfunction

  assign push       = op_val & op_ready;
  assign pop        = res_val & res_ready;
  assign fifo_full  = (count == CW'(DEPTH));
  assign fifo_empty = (count == '0);
  assign do_pop     = pop & ~fifo_empty;
  assign do_push    = push & (~fifo_full | do_pop);
  assign ovf_evt    = push & fifo_full & ~pop;
  assign udf_evt    = pop & fifo_empty;

  // Head is read before the same-edge write, so full push+pop compares the old entry
  assign head    = mem[rd_ptr];
  assign is_pass = do_pop & (head == res_data[4*DW-1:0]);
  assign is_fail = do_pop & (head != res_data[4*DW-1:0]);
  assign txn_idx = pass_cnt + fail_cnt;
  assign pending = count;

  assign unused_res_tag = ^res_data[4*DW+2:4*DW];

  always_ff @(posedge clk) begin
    if (do_push && !sw_rst) mem[wr_ptr] <= predict(op_data);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      mismatch       <= 1'b0;
      err_sticky     <= 1'b0;
      ovf_sticky     <= 1'b0;
      udf_sticky     <= 1'b0;
      first_fail_idx <= '0;
    end else if (sw_rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      mismatch       <= 1'b0;
      err_sticky     <= 1'b0;
      ovf_sticky     <= 1'b0;
      udf_sticky     <= 1'b0;
      first_fail_idx <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count + CW'(do_push) - CW'(do_pop);
      mismatch <= is_fail;
      if (is_pass && pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
      if (is_fail && fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
      if (is_fail) begin
        err_sticky <= 1'b1;
        if (!err_sticky) first_fail_idx <= txn_idx;
      end
      if (ovf_evt) ovf_sticky <= 1'b1;
      if (udf_evt) udf_sticky <= 1'b1;
    end
  end

endmodule
